// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised Mealy sequence detector: step
// classification and the elaboration-time KMP transition function.
package seq_det_pkg;

   localparam int unsigned MAX_LEN = 16;

   typedef enum logic [2:0] {
      STEP_HOLD,
      STEP_CLEAR,
      STEP_ADVANCE,
      STEP_MATCH,
      STEP_FALLBACK
   } step_e;

   function automatic int unsigned state_width(input int unsigned len);
      int unsigned w;
      w = (len <= 2) ? 1 : $clog2(len);
      return w;
   endfunction

   // i-th received bit of the pattern (bit 0 is the first received).
   function automatic logic pattern_bit(input logic [MAX_LEN-1:0] pat,
                                        input int unsigned len,
                                        input int unsigned i);
      logic b;
      b = pat[len-1-i];
      return b;
   endfunction

   // Next matched-prefix length after seeing bit b with s bits matched.
   // A completed match falls back to the longest proper border of the
   // whole pattern, or to 0 when overlapping detection is off.
   function automatic int unsigned kmp_next(input logic [MAX_LEN-1:0] pat,
                                            input int unsigned len,
                                            input int unsigned s,
                                            input logic b,
                                            input logic overlap);
      logic [MAX_LEN:0] seq;
      int unsigned      n;
      int unsigned      best;
      logic             ok;
      logic             is_match;
      seq  = '0;
      n    = s + 1;
      best = 0;
      for (int unsigned i = 0; i < s; i++) begin
         seq[i] = pattern_bit(pat, len, i);
      end
      seq[s]   = b;
      is_match = (n == len) && (b == pattern_bit(pat, len, s));
      for (int unsigned k = 1; (k <= n) && (k < len); k++) begin
         ok = 1'b1;
         for (int unsigned j = 0; j < k; j++) begin
            if (seq[n-k+j] != pattern_bit(pat, len, j)) ok = 1'b0;
         end
         if (ok) best = k;
      end
      if (is_match && !overlap) best = 0;
      return best;
   endfunction

endpackage

// File: rtl/seq_detector_mealy_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detector_mealy.sv
// Parametrised Mealy serial-pattern detector with enable, synchronous clear
// and a saturating match counter.
module seq_detector_mealy
   import seq_det_pkg::*;
#(
   parameter int unsigned            PATTERN_LEN = 4,
   parameter logic [MAX_LEN-1:0]     PATTERN     = 16'b1101,
   parameter bit                     OVERLAP     = 1'b1,
   parameter int unsigned            CNT_W       = 8,
   localparam int unsigned           STATE_W     = state_width(PATTERN_LEN)
) (
   input  logic               cp,
   input  logic               reset,
   input  logic               en,
   input  logic               clr,
   input  logic               x,
   output logic               y,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   match_cnt
);

   localparam int unsigned NUM_ST = 2 ** STATE_W;
   localparam logic [STATE_W-1:0] LAST = STATE_W'(PATTERN_LEN - 1);

   if ((PATTERN_LEN < 2) || (PATTERN_LEN > MAX_LEN)) begin : g_bad_len
      $error("seq_detector_mealy: PATTERN_LEN must be within 2..16");
   end
   if ((PATTERN >> PATTERN_LEN) != '0) begin : g_bad_pattern
      $error("seq_detector_mealy: PATTERN has bits above PATTERN_LEN");
   end

   logic [STATE_W-1:0] ns_tbl [NUM_ST][2];
   logic [NUM_ST-1:0]  exp_tbl;

   // Encodings above PATTERN_LEN-1 are unreachable; they map back to 0.
   for (genvar s = 0; s < NUM_ST; s++) begin : g_st
      if (s < PATTERN_LEN) begin : g_live
         localparam int unsigned NS0 = kmp_next(PATTERN, PATTERN_LEN, s, 1'b0, OVERLAP);
         localparam int unsigned NS1 = kmp_next(PATTERN, PATTERN_LEN, s, 1'b1, OVERLAP);
         assign ns_tbl[s][0] = NS0[STATE_W-1:0];
         assign ns_tbl[s][1] = NS1[STATE_W-1:0];
         assign exp_tbl[s]   = PATTERN[PATTERN_LEN-1-s];
      end else begin : g_dead
         assign ns_tbl[s][0] = '0;
         assign ns_tbl[s][1] = '0;
         assign exp_tbl[s]   = 1'b0;
      end
   end

   step_e              step;
   logic [STATE_W-1:0] next_state;
   logic               hit;

   always_ff @(posedge cp or posedge reset) begin
      if (reset) begin
         state <= '0;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      step       = STEP_HOLD;
      next_state = state;
      hit        = 1'b0;
      if (clr) begin
         step = STEP_CLEAR;
      end else if (en) begin
         if (x == exp_tbl[state]) begin
            step = (state == LAST) ? STEP_MATCH : STEP_ADVANCE;
         end else begin
            step = STEP_FALLBACK;
         end
      end
      case (step)
         STEP_CLEAR:    next_state = '0;
         STEP_ADVANCE:  next_state = ns_tbl[state][x];
         STEP_FALLBACK: next_state = ns_tbl[state][x];
         STEP_MATCH: begin
            next_state = ns_tbl[state][x];
            hit        = 1'b1;
         end
         default:       next_state = state;
      endcase
   end

   assign y = hit & ~reset;

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_match_cnt (
      .clk  (cp),
      .rst  (reset),
      .en   (y),
      .clr  (clr),
      .count(match_cnt)
   );

endmodule

// File: tb/tb_seq_detector_mealy.sv
// Directed self-checking bench for seq_detector_mealy (overlap, non-overlap,
// enable, reset/clear and saturation behaviour).
module tb_seq_detector_mealy;

   logic       cp;
   logic       reset;
   logic       en;
   logic       clr;
   logic       x;

   logic       y_ov,   y_nov,   y_sat;
   logic [1:0] st_ov,  st_nov,  st_sat;
   logic [7:0] cnt_ov, cnt_nov;
   logic [1:0] cnt_sat;

   int n_checks;
   int n_fail;

   seq_detector_mealy #(
      .PATTERN_LEN(4), .PATTERN(16'b1101), .OVERLAP(1'b1), .CNT_W(8)
   ) dut_ov (
      .cp(cp), .reset(reset), .en(en), .clr(clr), .x(x),
      .y(y_ov), .state(st_ov), .match_cnt(cnt_ov)
   );

   seq_detector_mealy #(
      .PATTERN_LEN(4), .PATTERN(16'b1101), .OVERLAP(1'b0), .CNT_W(8)
   ) dut_nov (
      .cp(cp), .reset(reset), .en(en), .clr(clr), .x(x),
      .y(y_nov), .state(st_nov), .match_cnt(cnt_nov)
   );

   seq_detector_mealy #(
      .PATTERN_LEN(4), .PATTERN(16'b1101), .OVERLAP(1'b1), .CNT_W(2)
   ) dut_sat (
      .cp(cp), .reset(reset), .en(en), .clr(clr), .x(x),
      .y(y_sat), .state(st_sat), .match_cnt(cnt_sat)
   );

   initial cp = 1'b0;
   always #5 cp = ~cp;

   task automatic set_in(input logic xb, input logic eb);
      @(negedge cp);
      x   = xb;
      en  = eb;
      clr = 1'b0;
      #1;
   endtask

   task automatic clock_in;
      @(posedge cp);
      #1;
   endtask

   task automatic clear_all;
      @(negedge cp);
      clr = 1'b1;
      en  = 1'b1;
      x   = 1'b0;
      @(posedge cp);
      #1;
      clr = 1'b0;
   endtask

   task automatic feed(input logic xb);
      set_in(xb, 1'b1);
      clock_in();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      en    = 1'b1;
      clr   = 1'b0;
      x     = 1'b1;
      #2;
      n_checks++;
      if ({y_ov, y_nov, y_sat} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_y: got %b%b%b expected 000", y_ov, y_nov, y_sat);
      end
      n_checks++;
      if ({st_ov, st_nov, st_sat} !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %0d %0d %0d expected 0 0 0", st_ov, st_nov, st_sat);
      end
      n_checks++;
      if ((cnt_ov !== 8'd0) || (cnt_nov !== 8'd0) || (cnt_sat !== 2'd0)) begin
         n_fail++;
         $display("FAIL reset_cnt: got %0d %0d %0d expected 0 0 0", cnt_ov, cnt_nov, cnt_sat);
      end
      @(negedge cp);
      reset = 1'b0;
   endtask

   task automatic test_overlap;
      int xs[7] = '{1, 1, 0, 1, 1, 0, 1};
      int ey[7] = '{0, 0, 0, 1, 0, 0, 1};
      int es[7] = '{1, 2, 3, 1, 2, 3, 1};
      clear_all();
      for (int i = 0; i < 7; i++) begin
         set_in(1'(xs[i]), 1'b1);
         n_checks++;
         if (y_ov !== 1'(ey[i])) begin
            n_fail++;
            $display("FAIL overlap_y bit %0d: got %b expected %0d", i + 1, y_ov, ey[i]);
         end
         clock_in();
         n_checks++;
         if (st_ov !== 2'(es[i])) begin
            n_fail++;
            $display("FAIL overlap_state bit %0d: got %0d expected %0d", i + 1, st_ov, es[i]);
         end
      end
      n_checks++;
      if (cnt_ov !== 8'd2) begin
         n_fail++;
         $display("FAIL overlap_cnt: got %0d expected 2", cnt_ov);
      end
   endtask

   task automatic test_no_overlap;
      int xs[7] = '{1, 1, 0, 1, 1, 0, 1};
      int ey[7] = '{0, 0, 0, 1, 0, 0, 0};
      int es[7] = '{1, 2, 3, 0, 1, 0, 1};
      clear_all();
      for (int i = 0; i < 7; i++) begin
         set_in(1'(xs[i]), 1'b1);
         n_checks++;
         if (y_nov !== 1'(ey[i])) begin
            n_fail++;
            $display("FAIL no_overlap_y bit %0d: got %b expected %0d", i + 1, y_nov, ey[i]);
         end
         clock_in();
         n_checks++;
         if (st_nov !== 2'(es[i])) begin
            n_fail++;
            $display("FAIL no_overlap_state bit %0d: got %0d expected %0d", i + 1, st_nov, es[i]);
         end
      end
      n_checks++;
      if (cnt_nov !== 8'd1) begin
         n_fail++;
         $display("FAIL no_overlap_cnt: got %0d expected 1", cnt_nov);
      end
   endtask

   task automatic test_fallback;
      int xs[5] = '{1, 1, 1, 0, 1};
      int ey[5] = '{0, 0, 0, 0, 1};
      int es[5] = '{1, 2, 2, 3, 1};
      clear_all();
      for (int i = 0; i < 5; i++) begin
         set_in(1'(xs[i]), 1'b1);
         n_checks++;
         if (y_ov !== 1'(ey[i])) begin
            n_fail++;
            $display("FAIL fallback_y bit %0d: got %b expected %0d", i + 1, y_ov, ey[i]);
         end
         clock_in();
         n_checks++;
         if (st_ov !== 2'(es[i])) begin
            n_fail++;
            $display("FAIL fallback_state bit %0d: got %0d expected %0d", i + 1, st_ov, es[i]);
         end
      end
      n_checks++;
      if ((cnt_ov !== 8'd1) || (st_nov !== 2'd0)) begin
         n_fail++;
         $display("FAIL fallback_end: got cnt %0d nov_state %0d expected 1 0", cnt_ov, st_nov);
      end
   endtask

   task automatic test_enable;
      int xs[8] = '{1, 1, 0, 0, 0, 0, 1, 1};
      int es_in[8] = '{1, 1, 0, 0, 0, 1, 0, 1};
      int ey[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
      int es[8] = '{1, 2, 2, 2, 2, 3, 3, 1};
      clear_all();
      for (int i = 0; i < 8; i++) begin
         set_in(1'(xs[i]), 1'(es_in[i]));
         n_checks++;
         if (y_ov !== 1'(ey[i])) begin
            n_fail++;
            $display("FAIL enable_y step %0d: got %b expected %0d", i + 1, y_ov, ey[i]);
         end
         clock_in();
         n_checks++;
         if (st_ov !== 2'(es[i])) begin
            n_fail++;
            $display("FAIL enable_state step %0d: got %0d expected %0d", i + 1, st_ov, es[i]);
         end
      end
      n_checks++;
      if (cnt_ov !== 8'd1) begin
         n_fail++;
         $display("FAIL enable_cnt: got %0d expected 1", cnt_ov);
      end
   endtask

   task automatic test_reset_mid;
      clear_all();
      feed(1'b1); feed(1'b1); feed(1'b0); feed(1'b1);
      feed(1'b1); feed(1'b0);
      n_checks++;
      if ((st_ov !== 2'd3) || (cnt_ov !== 8'd1)) begin
         n_fail++;
         $display("FAIL reset_mid_setup: got state %0d cnt %0d expected 3 1", st_ov, cnt_ov);
      end
      @(negedge cp);
      x  = 1'b1;
      en = 1'b1;
      #1;
      n_checks++;
      if (y_ov !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_pre_y: got %b expected 1", y_ov);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ((y_ov !== 1'b0) || (st_ov !== 2'd0) || (cnt_ov !== 8'd0)) begin
         n_fail++;
         $display("FAIL reset_mid_async: got y %b state %0d cnt %0d expected 0 0 0",
                  y_ov, st_ov, cnt_ov);
      end
      #1;
      reset = 1'b0;
      en    = 1'b0;
      clock_in();
      n_checks++;
      if (st_ov !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_mid_after: got state %0d expected 0", st_ov);
      end
   endtask

   task automatic test_clr_complete;
      clear_all();
      feed(1'b1); feed(1'b1); feed(1'b0); feed(1'b1);
      feed(1'b1); feed(1'b0);
      @(negedge cp);
      x   = 1'b1;
      en  = 1'b1;
      clr = 1'b1;
      #1;
      n_checks++;
      if ((y_ov !== 1'b0) || (cnt_ov !== 8'd1)) begin
         n_fail++;
         $display("FAIL clr_complete_pre: got y %b cnt %0d expected 0 1", y_ov, cnt_ov);
      end
      clock_in();
      clr = 1'b0;
      n_checks++;
      if ((st_ov !== 2'd0) || (cnt_ov !== 8'd0)) begin
         n_fail++;
         $display("FAIL clr_complete_post: got state %0d cnt %0d expected 0 0", st_ov, cnt_ov);
      end
   endtask

   task automatic test_saturation;
      int ec[5] = '{1, 2, 3, 3, 3};
      clear_all();
      feed(1'b1); feed(1'b1); feed(1'b0);
      for (int k = 0; k < 5; k++) begin
         set_in(1'b1, 1'b1);
         n_checks++;
         if (y_sat !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_y match %0d: got %b expected 1", k + 1, y_sat);
         end
         clock_in();
         n_checks++;
         if ((cnt_sat !== 2'(ec[k])) || (st_sat !== 2'd1)) begin
            n_fail++;
            $display("FAIL sat_cnt match %0d: got cnt %0d state %0d expected %0d 1",
                     k + 1, cnt_sat, st_sat, ec[k]);
         end
         if (k < 4) begin
            feed(1'b1);
            feed(1'b0);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_overlap();
      test_no_overlap();
      test_fallback();
      test_enable();
      test_reset_mid();
      test_clr_complete();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
